// File: rtl/rvfi_commit_fifo.sv
// Commit buffer behind the WB-stage RVFI monitor: drops flush bubbles, stamps retirement order,
// queues retired instructions for the trace sink and reports backpressure and lost commits.
package rvfi_commit_fifo_pkg;
    typedef struct packed {
        logic [31:0] rvfi_inst;
        logic [31:0] rvfi_pc_rdata;
        logic [31:0] rvfi_pc_wdata;
        logic [4:0]  rvfi_rd_addr;
        logic [31:0] rvfi_rd_wdata;
        logic        rvfi_trap;
    } rv32i_monitor_word;
endpackage

module rvfi_commit_fifo
    import rvfi_commit_fifo_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int STALL_MARGIN = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    commit_valid,
    input  rv32i_monitor_word       in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output rv32i_monitor_word       out_word,
    output logic [63:0]             out_order,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    stall_req,
    output logic                    overflow,
    output logic [15:0]             drop_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] MARGIN_C = CW'(STALL_MARGIN);

    rv32i_monitor_word mem_word  [DEPTH];
    logic [63:0]       mem_order [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [63:0]       order_q, order_d;
    logic              stall_q, stall_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       drop_q, drop_d;
    rv32i_monitor_word out_word_q, out_word_d;
    logic [63:0]       out_order_q, out_order_d;
    logic              push_req, pop, push, drop;

    always_comb begin
        push_req    = commit_valid && (in.rvfi_inst != 32'b0);
        pop         = (count_q != '0) && out_ready;
        push        = push_req && ((count_q < DEPTH_C) || pop);
        drop        = push_req && !push;

        wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        order_d     = push_req ? order_q + 64'd1 : order_q;
        overflow_d  = overflow_q || drop;
        drop_d      = (drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        // Stall is derived from next-state occupancy so out_ready never reaches it combinationally.
        stall_d = ((DEPTH_C - count_d) <= MARGIN_C);

        // Registered read of the next head; bypass when this edge writes the slot becoming head.
        out_word_d  = out_word_q;
        out_order_d = out_order_q;
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                out_word_d  = in;
                out_order_d = order_q;
            end else begin
                out_word_d  = mem_word[rd_ptr_d];
                out_order_d = mem_order[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            order_q     <= '0;
            stall_q     <= 1'b0;
            overflow_q  <= 1'b0;
            drop_q      <= '0;
            out_word_q  <= '0;
            out_order_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            order_q     <= order_d;
            stall_q     <= stall_d;
            overflow_q  <= overflow_d;
            drop_q      <= drop_d;
            out_word_q  <= out_word_d;
            out_order_q <= out_order_d;
        end
    end

    // Storage carries no reset; only the pointers decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_word[wr_ptr_q]  <= in;
            mem_order[wr_ptr_q] <= order_q;
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_word   = out_word_q;
    assign out_order  = out_order_q;
    assign count      = count_q;
    assign stall_req  = stall_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_rvfi_commit_fifo.sv
// Bench for rvfi_commit_fifo: scoreboard of expected head entries plus a table of
// per-cycle expectations for the backpressure/overflow scenario.
module tb_rvfi_commit_fifo;
    import rvfi_commit_fifo_pkg::*;

    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              commit_valid;
    rv32i_monitor_word in;
    logic              out_valid;
    logic              out_ready;
    rv32i_monitor_word out_word;
    logic [63:0]       out_order;
    logic [3:0]        count;
    logic              stall_req;
    logic              overflow;
    logic [15:0]       drop_count;

    always #5 clk = ~clk;

    rvfi_commit_fifo #(.DEPTH(DEPTH), .STALL_MARGIN(MARGIN)) dut (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .in(in),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_order(out_order), .count(count), .stall_req(stall_req),
        .overflow(overflow), .drop_count(drop_count)
    );

    typedef struct {
        rv32i_monitor_word word;
        logic [63:0]       order;
    } exp_t;

    typedef struct {
        logic        cv;
        logic [31:0] inst;
        logic        rdy;
        int          exp_cnt;
        logic        exp_stall;
        logic        exp_ovf;
        int          exp_drop;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        tbl[$];
    logic [63:0] m_order;
    logic        m_ovf;
    logic [15:0] m_drop;
    int          nvec = 0;
    int          nerr = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic rv32i_monitor_word mk_word(input logic [31:0] inst);
        rv32i_monitor_word w;
        w.rvfi_inst     = inst;
        w.rvfi_pc_rdata = $urandom;
        w.rvfi_pc_wdata = $urandom;
        w.rvfi_rd_addr  = 5'($urandom);
        w.rvfi_rd_wdata = $urandom;
        w.rvfi_trap     = 1'($urandom);
        return w;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_order = '0;
        m_ovf   = 1'b0;
        m_drop  = '0;
    endtask

    task automatic check_state(input string tag);
        int sz;
        sz = exp_q.size();
        chk({tag, ".count"},    160'(count),      160'(sz));
        chk({tag, ".valid"},    160'(out_valid),  160'(sz != 0));
        chk({tag, ".stall"},    160'(stall_req),  160'((DEPTH - sz) <= MARGIN));
        chk({tag, ".overflow"}, 160'(overflow),   160'(m_ovf));
        chk({tag, ".drops"},    160'(drop_count), 160'(m_drop));
        if (sz != 0) begin
            chk({tag, ".head_word"},  160'(out_word),  160'(exp_q[0].word));
            chk({tag, ".head_order"}, 160'(out_order), 160'(exp_q[0].order));
        end
    endtask

    // Called at a falling edge: drive one cycle, score the pop, advance past the rising edge, check.
    task automatic step(input logic cv, input logic [31:0] inst, input logic rdy, input string tag);
        rv32i_monitor_word w;
        exp_t e;
        bit   mpop, mfull;
        w = mk_word(inst);
        commit_valid = cv;
        in           = w;
        out_ready    = rdy;
        mpop  = (exp_q.size() != 0) && rdy;
        mfull = (exp_q.size() == DEPTH);
        #1;
        if (mpop) begin
            chk({tag, ".pop_word"},  160'(out_word),  160'(exp_q[0].word));
            chk({tag, ".pop_order"}, 160'(out_order), 160'(exp_q[0].order));
            e = exp_q.pop_front();
        end
        if (cv && (inst != 32'b0)) begin
            if (!mfull || mpop) begin
                e.word  = w;
                e.order = m_order;
                exp_q.push_back(e);
            end else begin
                m_ovf = 1'b1;
                if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end
            m_order = m_order + 64'd1;
        end
        @(negedge clk);
        check_state(tag);
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        commit_valid = 1'b0;
        out_ready    = 1'b0;
        in           = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (exp_q.size() != 0) step(1'b0, 32'b0, 1'b1, tag);
        end
    endtask

    task automatic add(input logic cv, input logic [31:0] inst, input logic rdy,
                       input int cnt, input logic ovf, input int drp);
        vec_t v;
        v.cv = cv; v.inst = inst; v.rdy = rdy; v.exp_cnt = cnt;
        v.exp_stall = (cnt >= 6); v.exp_ovf = ovf; v.exp_drop = drp;
        tbl.push_back(v);
    endtask

    initial begin
        // Backpressure table: fill 8, drop a 9th, drain, then one more commit (order 9).
        for (int i = 0; i < 8; i++) add(1'b1, 32'h0000_0013 + 32'(i << 20), 1'b0, i + 1, 1'b0, 0);
        add(1'b1, 32'h0040_0213, 1'b0, 8, 1'b1, 1);
        for (int i = 0; i < 8; i++) add(1'b0, 32'h0, 1'b1, 7 - i, 1'b1, 1);
        add(1'b1, 32'h0050_0293, 1'b0, 1, 1'b1, 1);

        rst          = 1'b1;
        commit_valid = 1'b0;
        out_ready    = 1'b0;
        in           = '0;
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        chk("rst.valid",    160'(out_valid),  160'(0));
        chk("rst.count",    160'(count),      160'(0));
        chk("rst.stall",    160'(stall_req),  160'(0));
        chk("rst.overflow", 160'(overflow),   160'(0));
        chk("rst.drops",    160'(drop_count), 160'(0));
        chk("rst.order",    160'(out_order),  160'(0));
        chk("rst.word",     160'(out_word),   160'(0));

        // Basic flow with the sink always ready.
        step(1'b1, 32'h0000_0013, 1'b1, "basic0");
        chk("basic0.order", 160'(out_order), 160'(0));
        step(1'b1, 32'h0010_0093, 1'b1, "basic1");
        chk("basic1.order", 160'(out_order), 160'(1));
        step(1'b1, 32'h0020_8113, 1'b1, "basic2");
        chk("basic2.order", 160'(out_order), 160'(2));
        drain("basic_drain");

        // Flush bubble between two real commits.
        do_reset();
        step(1'b1, 32'h0000_0013, 1'b0, "bub0");
        step(1'b1, 32'h0000_0000, 1'b0, "bub1");
        step(1'b1, 32'h0010_0093, 1'b0, "bub2");
        chk("bub.count", 160'(count), 160'(2));
        chk("bub.first_order", 160'(out_order), 160'(0));
        step(1'b0, 32'h0, 1'b1, "bub_pop");
        chk("bub.second_order", 160'(out_order), 160'(1));
        drain("bub_drain");

        // Table-driven backpressure, overflow and order gap.
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            string t;
            t = $sformatf("bp%0d", i);
            step(tbl[i].cv, tbl[i].inst, tbl[i].rdy, t);
            chk({t, ".tcount"}, 160'(count),      160'(tbl[i].exp_cnt));
            chk({t, ".tstall"}, 160'(stall_req),  160'(tbl[i].exp_stall));
            chk({t, ".tovf"},   160'(overflow),   160'(tbl[i].exp_ovf));
            chk({t, ".tdrop"},  160'(drop_count), 160'(tbl[i].exp_drop));
        end
        chk("bp.order_after_gap", 160'(out_order), 160'(9));
        drain("bp_drain");

        // Full with a simultaneous pop: push accepted, no overflow.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h0000_1013 + 32'(i), 1'b0, "fp_fill");
        step(1'b1, 32'h00a0_0513, 1'b1, "fp_pushpop");
        chk("fp.count", 160'(count), 160'(8));
        chk("fp.overflow", 160'(overflow), 160'(0));
        drain("fp_drain");

        // Asynchronous reset between edges with five entries buffered.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 32'h0000_2013 + 32'(i), 1'b0, "ar_fill");
        chk("ar.count5", 160'(count), 160'(5));
        #2 rst = 1'b0;
        #1;
        chk("ar.valid", 160'(out_valid), 160'(0));
        chk("ar.count", 160'(count),     160'(0));
        chk("ar.stall", 160'(stall_req), 160'(0));
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 32'h00b0_0593, 1'b0, "ar_first");
        chk("ar.first_order", 160'(out_order), 160'(0));
        drain("ar_drain");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/rvfi_commit_fifo.md
Name: rvfi_commit_fifo

Overview:
- Sits directly downstream of the WB-stage RVFI monitor register and consumes its output word at retirement.
- Filters flush bubbles and stamps each retired instruction with a 64-bit retirement order number.
- Buffers retired instructions in a small FIFO and drains them to the RVFI/trace sink over a valid/ready handshake.
- Provides a backpressure request and a sticky overflow flag, so a slow sink cannot silently lose commits.

Parameters:
- DEPTH, 8, number of FIFO entries; must be a power of 2 and at least 2.
- STALL_MARGIN, 2, stall_req asserts when free entries are at or below this value; range 1..DEPTH-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset); synchronous deassert handled externally.
- commit_valid  input  1  WB stage retires the instruction on `in` this cycle.
- in  input  rv32i_monitor_word  monitor word from the WB monitor register.
- out_valid  output  1  head entry available.
- out_ready  input  1  sink accepts the head entry.
- out_word  output  rv32i_monitor_word  head entry word.
- out_order  output  64  retirement order of the head entry.
- count  output  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- stall_req  output  1  request to the hazard unit to freeze WB.
- overflow  output  1  sticky: at least one commit was dropped.
- drop_count  output  16  number of dropped commits; saturates at 16'hFFFF.

Behaviour:
- Reset (rst=0, asynchronous), all outputs and state go to:
  - pointers = 0, count = 0, order counter = 0
  - out_valid = 0, overflow = 0, drop_count = 0
  - stall_req = 0, out_word = all zeros, out_order = 0
  - Entry contents need not be cleared.
- Commit qualification:
  - push_req = commit_valid && (in.rvfi_inst != 32'b0).
  - A word with inst = 0 is a flush bubble: it is ignored, consumes no order number, and does not affect any output.
- Pop:
  - pop = out_valid && out_ready.
  - The head pointer advances on the same edge; the next entry appears one cycle later via a registered read.
  - No pop occurs when empty; out_ready is ignored when out_valid = 0.
- Push accept:
  - push = push_req && (count < DEPTH || pop).
  - Full with a simultaneous pop: the push is accepted and count stays at DEPTH.
  - The entry stores {in, order}. The order counter increments by 1 on every push_req, whether accepted or dropped, so drops appear as gaps in out_order.
  - The order counter wraps modulo 2^64.
- Drop:
  - push_req while count == DEPTH and no pop: the entry is discarded.
  - overflow is set and held until reset.
  - drop_count increments, saturating at 16'hFFFF.
- Count update:
  - +1 on push only, −1 on pop only, unchanged on both or neither.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- Latency and empty case:
  - Write-then-read: an entry pushed at edge N is visible on out_* after edge N (out_valid = 1 in cycle N+1).
  - No combinational bypass from `in` to out_*.
  - out_word and out_order reflect the head entry whenever out_valid = 1; they are don't-care otherwise but must be stable (hold last value).
- Outputs:
  - out_valid = (count != 0).
  - stall_req = ((DEPTH − count) <= STALL_MARGIN), registered from next-state count so it has no combinational path from out_ready.
- Handshake stability: while out_valid = 1 and out_ready = 0, out_word and out_order must not change.
- Reset mid-operation: asserting rst at any time clears all state immediately (asynchronously); buffered entries are lost, and the order counter restarts at 0.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then rst=1 → out_valid=0, count=0, stall_req=0, overflow=0, out_order=0.
- Basic flow with out_ready=1: push 3 commits with inst=0x00000013, 0x00100093, 0x00208113 → out_valid in cycle after each push; out_order 0, 1, 2 in order; words match bit-exactly.
- Bubble filter: commit_valid=1 with inst=0 between two real commits → bubble never appears; the two real commits get orders 0 and 1.
- Backpressure with DEPTH=8, STALL_MARGIN=2, out_ready=0: push 6 → stall_req=1 the cycle after count reaches 6. Push 2 more → count=8. Push a 9th → overflow=1, drop_count=1, count=8. Drain all → out_order 0..7. Next accepted commit has out_order=9.
- Full with simultaneous pop: count=8, push_req=1 and out_ready=1 in the same cycle → count stays 8, overflow stays 0, the new entry appears after the existing 7.
- Async reset mid-stream: assert rst between clock edges with count=5 → out_valid=0 and count=0 before the next edge; after release, the first commit has out_order=0.
